// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with a one-word holding register.
// Words completing while the holding register is still occupied are dropped and flagged.
module serial_to_parallel #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  input  logic             s_data_i,
  input  logic             flush_i,
  input  logic             p_ready_i,
  input  logic             clr_ovr_i,
  output logic [WIDTH-1:0] p_data_o,
  output logic             p_valid_o,
  output logic             busy_o,
  output logic [CW-1:0]    bit_count_o,
  output logic             overrun_o
);

  typedef enum logic {IDLE, RECV} state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  pdata_q, pdata_d;
  logic              pvalid_q, pvalid_d;
  logic              ovr_q, ovr_d;

  logic              take, last, consume, drop;
  logic [WIDTH-1:0]  word;

  assign take    = s_valid_i && !flush_i;
  assign last    = take && (cnt_q == LAST_IDX);
  assign consume = pvalid_q && p_ready_i;
  assign word    = {s_data_i, shift_q[WIDTH-2:0]};
  assign drop    = last && pvalid_q && !p_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;

    // Flush wins over a same-cycle bit, so a would-be final bit never forms a word.
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (last) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (take) begin
      state_d = RECV;
      cnt_d   = cnt_q + CW'(1);
      shift_d = shift_q | (WIDTH'(s_data_i) << cnt_q);
    end

    // A consume on the completing edge frees the slot for the new word.
    if (last && (!pvalid_q || p_ready_i)) begin
      pdata_d  = word;
      pvalid_d = 1'b1;
    end else if (consume) begin
      pvalid_d = 1'b0;
    end

    ovr_d = drop || (ovr_q && !clr_ovr_i);
  end

  assign p_data_o    = pdata_q;
  assign p_valid_o   = pvalid_q;
  assign busy_o      = (state_q == RECV);
  assign bit_count_o = cnt_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboarded bench for serial_to_parallel: directed scenarios then random traffic,
// checked against a queue-of-bits reference model.
module tb_serial_to_parallel;
  localparam int WIDTH = 4;
  localparam int CW = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst, s_valid, s_data, flush, p_ready, clr_ovr;
  logic [WIDTH-1:0] p_data;
  logic p_valid, busy, overrun;
  logic [CW-1:0] bit_count;

  serial_to_parallel #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_data_i(s_data),
    .flush_i(flush), .p_ready_i(p_ready), .clr_ovr_i(clr_ovr),
    .p_data_o(p_data), .p_valid_o(p_valid), .busy_o(busy),
    .bit_count_o(bit_count), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model: collected bits, holding-slot occupancy, sticky flag, last loaded word.
  bit              bits[$];
  bit              held_m = 0;
  bit              ovr_m = 0;
  int              last_word = 0;
  int              exp_q[$];

  function automatic void check(bit ok, string name, int act, int exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_edge(bit r, bit sv, bit sd, bit fl, bit pr, bit co);
    int w;
    bit set_ovr = 0;
    bit done = 0;
    if (r) begin
      bits.delete(); exp_q.delete();
      held_m = 0; ovr_m = 0; last_word = 0;
      return;
    end
    if (fl) bits.delete();
    else if (sv) begin
      bits.push_back(sd);
      if (bits.size() == WIDTH) begin
        w = 0;
        foreach (bits[i]) w += int'(bits[i]) << i;
        bits.delete();
        done = 1;
        if (!held_m || pr) begin
          exp_q.push_back(w); held_m = 1; last_word = w;
        end else set_ovr = 1;
      end
    end
    if (!done && held_m && pr) held_m = 0;
    if (set_ovr) ovr_m = 1;
    else if (co) ovr_m = 0;
  endfunction

  task automatic step(bit r, bit sv, bit sd, bit fl, bit pr, bit co);
    rst = r; s_valid = sv; s_data = sd; flush = fl; p_ready = pr; clr_ovr = co;
    @(posedge clk);
    model_edge(r, sv, sd, fl, pr, co);
    #1;
    check(int'(bit_count) == bits.size(), "bit_count", int'(bit_count), bits.size());
    check(busy == (bits.size() != 0), "busy", int'(busy), int'(bits.size() != 0));
    check(p_valid == held_m, "p_valid", int'(p_valid), int'(held_m));
    check(overrun == ovr_m, "overrun", int'(overrun), int'(ovr_m));
    check(int'(p_data) == last_word, "p_data", int'(p_data), last_word);
  endtask

  task automatic send(int w, bit pr, int gap);
    for (int i = 0; i < WIDTH; i++) begin
      step(0, 1, w[i], 0, pr, 0);
      for (int g = 0; g < gap; g++) step(0, 0, 0, 0, pr, 0);
    end
  endtask

  // Monitor: a handshake seen before the edge consumes the oldest expected word.
  always @(negedge clk) begin
    if (!rst && p_valid && p_ready) begin
      if (exp_q.size() == 0) check(0, "unexpected_word", int'(p_data), -1);
      else begin
        int e;
        e = exp_q.pop_front();
        check(int'(p_data) == e, "word", int'(p_data), e);
      end
    end
  end

  initial begin
    rst = 1; s_valid = 0; s_data = 0; flush = 0; p_ready = 0; clr_ovr = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Basic: 1,0,1,1 -> D
    send(4'hD, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // Gapped 0,1,1,0 -> 6
    send(4'h6, 1, 3);
    step(0, 0, 0, 0, 1, 0);
    // Overrun: A held, 5 dropped
    send(4'hA, 0, 0);
    send(4'h5, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // Consume on the completing edge
    send(4'h3, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // Flush mid-word, then full F, then flush on the final bit
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    send(4'hF, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // Reset with partial word and held word
    send(4'h7, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    send(4'h9, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(99) == 0, $urandom_range(3) != 0, 1'($urandom),
           $urandom_range(19) == 0, $urandom_range(2) != 0, $urandom_range(9) == 0);

    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 1, 0);
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Receive-side counterpart to the 4-bit parallel-to-serial transmitter. Collects a valid-qualified, LSB-first serial bit stream into WIDTH-bit words and presents each completed word on a registered parallel output with a valid/ready handshake. A one-word holding register decouples assembly from the downstream consumer. Words completing while the holding register is still occupied are dropped and flagged.

## Interface
- WIDTH, 4, word width in bits (≥2); bit_count width is clog2(WIDTH+1)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- s_valid  input  1  s_data carries a bit this cycle
- s_data  input  1  serial bit, LSB of word first
- flush  input  1  discard partially assembled word
- p_ready  input  1  consumer accepts p_data this cycle
- clr_ovr  input  1  clear sticky overrun flag
- p_data  output  WIDTH  assembled word (holding register)
- p_valid  output  1  p_data holds an unconsumed word
- busy  output  1  partial word in progress (state RECV)
- bit_count  output  clog2(WIDTH+1)  bits collected in current word
- overrun  output  1  sticky: a completed word was dropped

## Operation
- FSM: IDLE (bit_count==0, busy=0), RECV (1..WIDTH-1 bits held, busy=1).
- Sample: on edge with s_valid=1 and flush=0, bit enters shift register at position bit_count (LSB first), bit_count+1; IDLE→RECV on first bit.
- Completion: edge sampling bit WIDTH-1 forms word {s_data, shift[WIDTH-2:0]}; bit_count→0, state→IDLE.
  - Holding free (p_valid=0) or being consumed this cycle (p_valid & p_ready): p_data←word, p_valid←1.
  - Holding occupied and p_ready=0: word dropped, p_data/p_valid unchanged, overrun←1.
- Consume: p_valid & p_ready with no completion that edge → p_valid←0; p_data keeps last value.
- s_valid=0: no shift, no count change; gaps of any length between bits are legal.
- flush: bit_count←0, shift register←0, state→IDLE; overrides a same-cycle s_valid bit, including the would-be final bit (no word produced). Does not touch p_data, p_valid, overrun.
- overrun: set on dropped word; cleared by clr_ovr; simultaneous set and clear → stays 1.
- p_ready ignored while p_valid=0.

## Timing
- Reset values: p_data=0, p_valid=0, busy=0, bit_count=0, overrun=0, shift register=0, state IDLE. Reset mid-word discards the partial word and any held word.
- Latency: p_valid and p_data updated on the same edge that samples the final bit (visible the following cycle); minimum word period WIDTH cycles.
- Throughput: back-to-back words with s_valid held high need no gap, provided p_ready is asserted at least once per WIDTH cycles.
- All outputs are registered; no combinational path from input to output.
- Stream compatibility: one transmitter frame (load then WIDTH shifts) decodes to its loaded word when transmitter valid drives s_valid.

## Test plan
- Basic: WIDTH=4, p_ready=1, s_valid=1, bits 1,0,1,1 → p_valid=1 for one cycle after 4th edge, p_data=4'hD, busy 1 for cycles 2–4 (after edges 1–3), overrun=0.
- Gapped input: bits 0,1,1,0 with s_valid low 3 cycles between each → p_data=4'h6; bit_count holds during gaps.
- Overrun: p_ready=0, send 4'hA then 4'h5 → p_data stays 4'hA, overrun=1; p_ready=1 → p_valid drops, overrun stays 1 until clr_ovr.
- Simultaneous consume and complete: hold 4'h3, assert p_ready on edge completing 4'hC → p_valid stays 1, p_data=4'hC, overrun=0.
- Flush: 2 bits sent, then flush with s_valid=1 → bit_count=0, busy=0; next 4 bits 1,1,1,1 → p_data=4'hF. Flush on the 4th-bit cycle → no p_valid.
- Reset mid-word and with held word: rst after 3 bits while p_valid=1 → all outputs 0 next cycle; subsequent 4'h9 received correctly.
